// File: rtl/inst_sram_resp_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the instruction SRAM responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package inst_sram_resp_pkg;

  // Strips the kseg0/kseg1 segment bits to get a physical address.
  localparam logic [31:0] KSEG_MASK    = 32'h1fffffff;
  // Physical base of the MIPS boot window.
  localparam logic [31:0] DEFAULT_BASE = 32'h1fc00000;
  localparam int          WORD_W       = 32;
  localparam int          BE_W         = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Virtual-to-physical translation for the unmapped kernel segments.
  function automatic logic [31:0] kseg_phys(input logic [31:0] vaddr);
    return vaddr & KSEG_MASK;
  endfunction

endpackage

// File: rtl/inst_sram_resp_sram_word_array.sv
`timescale 1ns/1ps
// Word storage: one asynchronous read port and two synchronous write ports.
// Latency: read is combinational, so the caller's output register sees pre-write data (read-first).
// Backpressure: none; a loader write wins over a CPU write to the same index.
module sram_word_array
  import inst_sram_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_rd_idx,
  output logic [WORD_W-1:0] o_rd_dat,
  input  logic [BE_W-1:0]   i_cpu_be,
  input  logic [ADDR_W-1:0] i_cpu_idx,
  input  logic [WORD_W-1:0] i_cpu_dat,
  input  logic              i_ld_vld,
  input  logic [ADDR_W-1:0] i_ld_idx,
  input  logic [WORD_W-1:0] i_ld_dat
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] r_mem [0:DEPTH-1];
  logic [BE_W-1:0]   w_cpu_be;

  assign o_rd_dat = r_mem[i_rd_idx];

  // CPU bytes are dropped entirely when the loader targets the same word.
  always_comb begin
    w_cpu_be = i_cpu_be;
    if (i_ld_vld && (i_ld_idx == i_cpu_idx)) begin
      w_cpu_be = '0;
    end
  end

  // Both write ports commit on the same edge; they never overlap after masking.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (w_cpu_be[b]) begin
        r_mem[i_cpu_idx][8*b +: 8] <= i_cpu_dat[8*b +: 8];
      end
    end
    if (i_ld_vld) begin
      r_mem[i_ld_idx] <= i_ld_dat;
    end
  end

endmodule

// File: rtl/inst_sram_resp.sv
`timescale 1ns/1ps
// Instruction SRAM responder for the kseg boot window, with post-reset clear sweep and program loader.
// Latency: one cycle from request to inst_sram_rdata; rdata holds between requests.
// Backpressure: none; requests and loader writes are accepted every RUN cycle and ignored during INIT.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int          ADDR_W         = 12,
  parameter logic [31:0] BASE           = DEFAULT_BASE,
  parameter int          CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_wen,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              mem_ready,
  output logic [15:0]       oob_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_clear_ptr;
  logic              r_mem_ready;
  logic [31:0]       r_rdata;
  logic [15:0]       r_oob_count;

  logic [31:0]       w_phys;
  logic              w_hit;
  logic [ADDR_W-1:0] w_idx;
  logic              w_run;
  logic [31:0]       w_rd_dat;
  logic [BE_W-1:0]   w_cpu_be;
  logic              w_ld_vld;
  logic [ADDR_W-1:0] w_ld_idx;
  logic [31:0]       w_ld_dat;
  logic              w_unused_addr;

  // Byte offset is irrelevant for word accesses.
  assign w_unused_addr = ^inst_sram_addr[1:0];

  assign w_phys = kseg_phys(inst_sram_addr);
  assign w_hit  = (w_phys[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign w_idx  = w_phys[ADDR_W+1:2];
  assign w_run  = (r_state == ST_RUN);

  // CPU writes only land on in-window requests while running.
  assign w_cpu_be = (w_run && inst_sram_en && w_hit) ? inst_sram_wen : '0;

  // The clear sweep borrows the loader port; external loads are ignored until RUN.
  assign w_ld_vld = w_run ? ld_valid : 1'b1;
  assign w_ld_idx = w_run ? ld_addr  : r_clear_ptr;
  assign w_ld_dat = w_run ? ld_data  : 32'h0;

  sram_word_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .i_rd_idx  (w_idx),
    .o_rd_dat  (w_rd_dat),
    .i_cpu_be  (w_cpu_be),
    .i_cpu_idx (w_idx),
    .i_cpu_dat (inst_sram_wdata),
    .i_ld_vld  (w_ld_vld),
    .i_ld_idx  (w_ld_idx),
    .i_ld_dat  (w_ld_dat)
  );

  // INIT/RUN sequencing: sweep every index once, then raise mem_ready on the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      r_clear_ptr <= '0;
      r_mem_ready <= (CLEAR_ON_RESET == 0);
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clear_ptr <= r_clear_ptr + 1'b1;
          if (r_clear_ptr == LAST_IDX) begin
            r_state     <= ST_RUN;
            r_mem_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Read data register: captures the pre-write word on a hit, zero on a miss, holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_run && inst_sram_en) begin
      r_rdata <= w_hit ? w_rd_dat : 32'h0;
    end
  end

  // Out-of-window request counter, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oob_count <= '0;
    end else if (w_run && inst_sram_en && !w_hit && (r_oob_count != 16'hffff)) begin
      r_oob_count <= r_oob_count + 16'd1;
    end
  end

  assign inst_sram_rdata = r_rdata;
  assign mem_ready       = r_mem_ready;
  assign oob_count       = r_oob_count;

endmodule

// File: tb/tb_inst_sram_resp.sv
`timescale 1ns/1ps
// Self-checking bench for inst_sram_resp with a 16-word window and clear-on-reset.
module tb_inst_sram_resp;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] WBASE = 32'h1fc00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ld_valid;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        mem_ready;
  logic [15:0] oob_count;

  always #5 clk = ~clk;

  inst_sram_resp #(
    .ADDR_W         (AW),
    .BASE           (WBASE),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .ld_valid        (ld_valid),
    .ld_addr         (ld_addr),
    .ld_data         (ld_data),
    .mem_ready       (mem_ready),
    .oob_count       (oob_count)
  );

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic [15:0] m_oob;
  logic        m_ready;
  int          m_init_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Window membership by plain address arithmetic on the physical address.
  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] p;
    p = a & 32'h1fffffff;
    return (p >= WBASE) && (p < WBASE + 32'(DEPTH * 4));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] p;
    p = a & 32'h1fffffff;
    return int'((p - WBASE) >> 2);
  endfunction

  task automatic model_reset();
    m_rdata    = 32'h0;
    m_oob      = 16'h0;
    m_ready    = 1'b0;
    m_init_cnt = 0;
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, check 1ns later.
  task automatic cycle(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wd, input bit lv, input logic [3:0] la,
                       input logic [31:0] ldat, input string tag);
    int idx;
    bit hit;
    inst_sram_en    = en;
    inst_sram_wen   = wen;
    inst_sram_addr  = addr;
    inst_sram_wdata = wd;
    ld_valid        = lv;
    ld_addr         = la;
    ld_data         = ldat;
    @(posedge clk);
    if (!m_ready) begin
      m_init_cnt++;
      if (m_init_cnt == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      end
    end else begin
      hit = in_win(addr);
      idx = hit ? word_of(addr) : 0;
      if (en) begin
        if (hit) m_rdata = m_mem[idx];
        else begin
          m_rdata = 32'h0;
          if (m_oob != 16'hffff) m_oob = m_oob + 16'd1;
        end
      end
      if (en && hit && (wen != 4'h0) && !(lv && (int'(la) == idx))) begin
        for (int b = 0; b < 4; b++)
          if (wen[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
      if (lv) m_mem[la] = ldat;
    end
    #1;
    if (chk_on) begin
      chk({tag, "/rdata"}, inst_sram_rdata, m_rdata);
      chk({tag, "/oob"}, {16'h0, oob_count}, {16'h0, m_oob});
      chk({tag, "/ready"}, {31'h0, mem_ready}, {31'h0, m_ready});
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int need;

    reset = 1'b1;
    inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    ld_valid = 1'b0; ld_addr = 4'h0; ld_data = 32'h0;
    model_reset();
    #1;
    chk("rst/rdata", inst_sram_rdata, 32'h0);
    chk("rst/oob", {16'h0, oob_count}, 32'h0);
    chk("rst/ready", {31'h0, mem_ready}, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // INIT: requests and loads are ignored; interrupt at cycle 7
    for (int i = 0; i < 7; i++) begin
      if (i == 3) cycle(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b1, 4'h0, 32'h12345678, "init_rd");
      else if (i == 4) cycle(1'b1, 4'hf, 32'hbfc00004, 32'hdeadbeef, 1'b0, 4'h0, 32'h0, "init_wr");
      else if (i == 5) cycle(1'b1, 4'h0, 32'h00000000, 32'h0, 1'b0, 4'h0, 32'h0, "init_miss");
      else idle("init");
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midinit_rst/rdata", inst_sram_rdata, 32'h0);
    chk("midinit_rst/ready", {31'h0, mem_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 9) cycle(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b0, 4'h0, 32'h0, "init2_rd");
      else idle("init2");
    end
    chk("ready_after_16", {31'h0, mem_ready}, 32'h1);

    // Loader then read, held while idle
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h3c1dbfc0, "ld0");
    cycle(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b0, 4'h0, 32'h0, "rd0");
    chk("boot_word", inst_sram_rdata, 32'h3c1dbfc0);
    idle("hold1");
    idle("hold2");
    chk("boot_word_held", inst_sram_rdata, 32'h3c1dbfc0);

    // Byte-masked write, read-first
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h1, 32'h11223344, "ld1");
    cycle(1'b1, 4'b0110, 32'hbfc00004, 32'haabbccdd, 1'b0, 4'h0, 32'h0, "bytewr");
    chk("bytewr_old", inst_sram_rdata, 32'h11223344);
    cycle(1'b1, 4'h0, 32'hbfc00004, 32'h0, 1'b0, 4'h0, 32'h0, "bytewr_rd");
    chk("bytewr_new", inst_sram_rdata, 32'h11bbcc44);

    // Miss
    cycle(1'b1, 4'hf, 32'h00000000, 32'hffffffff, 1'b0, 4'h0, 32'h0, "miss0");
    chk("miss_cnt", {16'h0, oob_count}, 32'h1);
    cycle(1'b1, 4'h0, 32'hbfc00040, 32'h0, 1'b0, 4'h0, 32'h0, "miss_past");

    // Same-cycle collisions
    cycle(1'b1, 4'hf, 32'hbfc00008, 32'h2, 1'b1, 4'h2, 32'h1, "coll_same");
    cycle(1'b1, 4'h0, 32'hbfc00008, 32'h0, 1'b0, 4'h0, 32'h0, "coll_same_rd");
    chk("coll_same_val", inst_sram_rdata, 32'h1);
    cycle(1'b1, 4'hf, 32'hbfc00014, 32'h55, 1'b1, 4'h3, 32'hdeadbeef, "coll_diff");
    cycle(1'b1, 4'h0, 32'hbfc0000c, 32'h0, 1'b0, 4'h0, 32'h0, "coll_rd3");
    chk("coll_w3", inst_sram_rdata, 32'hdeadbeef);
    cycle(1'b1, 4'h0, 32'hbfc00014, 32'h0, 1'b0, 4'h0, 32'h0, "coll_rd5");
    chk("coll_w5", inst_sram_rdata, 32'h55);
    cycle(1'b1, 4'h0, 32'h9fc0000c, 32'h0, 1'b1, 4'h3, 32'h0badf00d, "ld_rd_same");
    chk("ld_rd_old", inst_sram_rdata, 32'hdeadbeef);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'hbfc00000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
        1: a = 32'h9fc00000 + ($urandom_range(0, 15) << 2);
        2: a = 32'hbfc00040 + ($urandom_range(0, 63) << 2);
        default: a = $urandom;
      endcase
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
            a, $urandom, ($urandom_range(0, 9) < 3), 4'($urandom), $urandom, "rand");
    end

    // Drive the counter to saturation
    need = int'(16'hfffd - m_oob);
    chk_on = 1'b0;
    for (int i = 0; i < need; i++) cycle(1'b1, 4'h0, 32'h00000100, 32'h0, 1'b0, 4'h0, 32'h0, "fill");
    chk_on = 1'b1;
    chk("oob_near", {16'h0, oob_count}, 32'h0000fffd);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'h0, 32'h80000000, 32'h0, 1'b0, 4'h0, 32'h0, "sat");
    chk("oob_sat", {16'h0, oob_count}, 32'h0000ffff);

    // Reset in RUN clears outputs asynchronously and re-sweeps the array
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'hcafef00d, "ld_pre");
    cycle(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b0, 4'h0, 32'h0, "rd_pre");
    chk("rd_pre_val", inst_sram_rdata, 32'hcafef00d);
    inst_sram_en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("run_rst/rdata", inst_sram_rdata, 32'h0);
    chk("run_rst/oob", {16'h0, oob_count}, 32'h0);
    chk("run_rst/ready", {31'h0, mem_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) idle("init3");
    cycle(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b0, 4'h0, 32'h0, "rd_cleared");
    chk("cleared_word", inst_sram_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
